// File: rtl/enigma_pkg.sv
// Shared constants and helpers for the enigma stream cipher: alphabet size,
// character codes, the per-map reflection constants and letter classification.
package enigma_pkg;

   localparam int LETTERS = 26;

   localparam logic [7:0] CHAR_UA = 8'h41;
   localparam logic [7:0] CHAR_UZ = 8'h5A;
   localparam logic [7:0] CHAR_LA = 8'h61;
   localparam logic [7:0] CHAR_LZ = 8'h7A;

   // Odd constants keep every map fixed-point free and self-inverse.
   function automatic logic [4:0] map_const(input int unsigned k);
      logic [4:0] c;
      case (k)
         32'd0:   c = 5'd3;
         32'd1:   c = 5'd11;
         32'd2:   c = 5'd17;
         32'd3:   c = 5'd25;
         default: begin
            c    = 5'((32'd8 * k + 32'd3) % 32'd26);
            c[0] = 1'b1;
         end
      endcase
      return c;
   endfunction

   function automatic logic is_letter(input logic [7:0] ch);
      return ((ch >= CHAR_UA) && (ch <= CHAR_UZ)) ||
             ((ch >= CHAR_LA) && (ch <= CHAR_LZ));
   endfunction

endpackage

// File: rtl/enigma_stream_cipher_map_unit.sv
// Combinational letter substitution: oidx = (C[sel] + 2*rotor - idx) mod 26,
// case preserved, non-letters passed through untouched.
module enigma_map_unit
   import enigma_pkg::*;
#(
   parameter int SEL_W = 2
)(
   input  logic [7:0]       in_char,
   input  logic [SEL_W-1:0] sel,
   input  logic [4:0]       rotor,
   output logic [7:0]       out_char,
   output logic             letter
);

   logic [4:0] idx_s;
   logic [6:0] sum_s;
   logic [6:0] oidx_s;

   // Substitute one character through the selected reflection map
   always_comb begin
      letter = is_letter(in_char);
      // 'A' and 'a' both have 5'd1 in their low bits, so idx is the low bits minus one.
      idx_s  = in_char[4:0] - 5'd1;
      sum_s  = {2'b00, map_const(32'(sel))} + {1'b0, rotor, 1'b0} + 7'd26 - {2'b00, idx_s};
      oidx_s = sum_s % 7'd26;
      if (letter) begin
         out_char = {in_char[7:5], 5'b00000} + {1'b0, oidx_s} + 8'd1;
      end else begin
         out_char = in_char;
      end
   end

endmodule

// File: rtl/enigma_stream_cipher.sv
// Streaming letter cipher: key register file, key pointer / rotor counters,
// one registered output stage with valid/ready handshake.
module enigma_stream_cipher
   import enigma_pkg::*;
#(
   parameter  int NUM_MAPS = 4,
   parameter  int KEY_LEN  = 4,
   parameter  int ROTOR_EN = 1,
   localparam int SEL_W    = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1,
   localparam int IDX_W    = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   input  logic             key_we,
   input  logic [IDX_W-1:0] key_waddr,
   input  logic [SEL_W-1:0] key_wdata,
   input  logic             key_len_we,
   input  logic [IDX_W:0]   key_len_data,
   input  logic             msg_start,
   output logic [IDX_W-1:0] key_ptr,
   output logic [4:0]       rotor_pos
);

   logic [KEY_LEN-1:0][SEL_W-1:0] key_q, key_d;
   logic [IDX_W:0]                key_len_q, key_len_d;
   logic [IDX_W-1:0]              key_ptr_q, key_ptr_d;
   logic [4:0]                    rotor_q, rotor_d;
   logic                          out_valid_q, out_valid_d;
   logic [7:0]                    out_data_q, out_data_d;

   logic             in_ready_s;
   logic             accept_s;
   logic [IDX_W-1:0] cur_ptr_s;
   logic [4:0]       cur_rot_s;
   logic [4:0]       map_rot_s;
   logic [SEL_W-1:0] sel_s;
   logic [IDX_W:0]   last_idx_s;
   logic [7:0]       mapped_s;
   logic             letter_s;

   // Handshake and the pointer/rotor values seen by this cycle's character
   always_comb begin
      in_ready_s = !out_valid_q || out_ready;
      accept_s   = in_valid && in_ready_s;
      if (msg_start) begin
         cur_ptr_s = {IDX_W{1'b0}};
         cur_rot_s = 5'd0;
      end else begin
         cur_ptr_s = key_ptr_q;
         cur_rot_s = rotor_q;
      end
      map_rot_s  = (ROTOR_EN != 0) ? cur_rot_s : 5'd0;
      sel_s      = key_q[cur_ptr_s];
      last_idx_s = key_len_q - {{IDX_W{1'b0}}, 1'b1};
   end

   enigma_map_unit #(.SEL_W(SEL_W)) u_map (
      .in_char  (in_data),
      .sel      (sel_s),
      .rotor    (map_rot_s),
      .out_char (mapped_s),
      .letter   (letter_s)
   );

   // Next-state for counters, key storage and the output register
   always_comb begin
      key_ptr_d = cur_ptr_s;
      rotor_d   = cur_rot_s;
      if (accept_s && letter_s) begin
         // ">=" also catches a pointer stranded beyond a freshly shortened key.
         if ({1'b0, cur_ptr_s} >= last_idx_s) begin
            key_ptr_d = {IDX_W{1'b0}};
         end else begin
            key_ptr_d = cur_ptr_s + IDX_W'(1'b1);
         end
         if (cur_rot_s == 5'd25) begin
            rotor_d = 5'd0;
         end else begin
            rotor_d = cur_rot_s + 5'd1;
         end
      end else begin
         key_ptr_d = cur_ptr_s;
         rotor_d   = cur_rot_s;
      end

      key_d = key_q;
      if (key_we && (int'(key_waddr) < KEY_LEN)) begin
         key_d[key_waddr] = key_wdata;
      end else begin
         key_d = key_q;
      end

      key_len_d = key_len_q;
      if (key_len_we) begin
         if (key_len_data == {(IDX_W+1){1'b0}}) begin
            key_len_d = {{IDX_W{1'b0}}, 1'b1};
         end else if (key_len_data > (IDX_W+1)'(KEY_LEN)) begin
            key_len_d = (IDX_W+1)'(KEY_LEN);
         end else begin
            key_len_d = key_len_data;
         end
      end else begin
         key_len_d = key_len_q;
      end

      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (accept_s) begin
         out_valid_d = 1'b1;
         out_data_d  = mapped_s;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
         out_data_d  = out_data_q;
      end else begin
         out_valid_d = out_valid_q;
         out_data_d  = out_data_q;
      end
   end

   // State registers; reset also wipes the key, so the host must reprogram it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q       <= {(KEY_LEN*SEL_W){1'b0}};
         key_len_q   <= (IDX_W+1)'(KEY_LEN);
         key_ptr_q   <= {IDX_W{1'b0}};
         rotor_q     <= 5'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
      end else begin
         key_q       <= key_d;
         key_len_q   <= key_len_d;
         key_ptr_q   <= key_ptr_d;
         rotor_q     <= rotor_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign key_ptr   = key_ptr_q;
   assign rotor_pos = rotor_q;

endmodule

// File: tb/tb_enigma_stream_cipher.sv
// Scoreboard bench: a rotor-enabled and a static instance share stimulus; a
// letter-arithmetic reference model queues expected characters per instance.
module tb_enigma_stream_cipher;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0, out_ready = 1'b1, msg_start = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       key_we = 1'b0, key_len_we = 1'b0;
   logic [1:0] key_waddr = 2'd0, key_wdata = 2'd0;
   logic [2:0] key_len_data = 3'd0;

   logic       ir_rot, ov_rot, ir_sta, ov_sta;
   logic [7:0] od_rot, od_sta;
   logic [1:0] kp_rot, kp_sta;
   logic [4:0] rp_rot, rp_sta;

   int n_tests = 0;
   int n_fail  = 0;
   byte unsigned q_rot[$];
   byte unsigned q_sta[$];

   int cmap[4] = '{3, 11, 17, 25};
   int m_key[4];
   int m_len, m_ptr, m_rot;
   bit m_v;

   always #5 clk = ~clk;

   enigma_stream_cipher #(.NUM_MAPS(4), .KEY_LEN(4), .ROTOR_EN(1)) u_rot (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_rot), .in_data(in_data),
      .out_valid(ov_rot), .out_ready(out_ready), .out_data(od_rot),
      .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
      .key_len_we(key_len_we), .key_len_data(key_len_data), .msg_start(msg_start),
      .key_ptr(kp_rot), .rotor_pos(rp_rot));

   enigma_stream_cipher #(.NUM_MAPS(4), .KEY_LEN(4), .ROTOR_EN(0)) u_sta (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_sta), .in_data(in_data),
      .out_valid(ov_sta), .out_ready(out_ready), .out_data(od_sta),
      .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
      .key_len_we(key_len_we), .key_len_data(key_len_data), .msg_start(msg_start),
      .key_ptr(kp_sta), .rotor_pos(rp_sta));

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic bit is_let(input byte unsigned ch);
      return (ch >= 8'h41 && ch <= 8'h5A) || (ch >= 8'h61 && ch <= 8'h7A);
   endfunction

   // Reflection through C[sel] shifted by twice the rotor position, case kept
   function automatic byte unsigned ref_char(input byte unsigned ch, input int sel, input int r);
      byte unsigned base;
      int idx;
      if (!is_let(ch)) return ch;
      base = (ch <= 8'h5A) ? 8'h41 : 8'h61;
      idx  = int'(ch) - int'(base);
      return base + 8'((((cmap[sel] + 2 * r - idx) % 26) + 26) % 26);
   endfunction

   function automatic byte unsigned rand_char();
      int k;
      byte unsigned odd[5];
      odd = '{8'h40, 8'h5B, 8'h60, 8'h7B, 8'h20};
      k = $urandom_range(0, 9);
      if (k < 5)      return 8'h41 + 8'($urandom_range(0, 25));
      else if (k < 8) return 8'h61 + 8'($urandom_range(0, 25));
      else if (k == 8) return 8'h30 + 8'($urandom_range(0, 9));
      else            return odd[$urandom_range(0, 4)];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_key[i] = 0;
      m_len = 4; m_ptr = 0; m_rot = 0; m_v = 1'b0;
   endtask

   // One clock of stimulus; the model predicts acceptance and pushes expectations
   task automatic drive(input bit v, input byte unsigned d, input bit ordy, input bit ms,
                        input bit kwe, input int kaddr, input int kdata,
                        input bit lwe, input int ldata,
                        input bit dir, input byte unsigned er, input byte unsigned es);
      bit acc;
      int cp, cr;
      @(posedge clk); #1;
      chk("out_valid_rot", ov_rot, m_v);
      chk("out_valid_sta", ov_sta, m_v);
      chk("key_ptr_rot", kp_rot, m_ptr);
      chk("key_ptr_sta", kp_sta, m_ptr);
      chk("rotor_pos_rot", rp_rot, m_rot);
      chk("rotor_pos_sta", rp_sta, m_rot);
      in_valid = v; in_data = d; out_ready = ordy; msg_start = ms;
      key_we = kwe; key_waddr = 2'(kaddr); key_wdata = 2'(kdata);
      key_len_we = lwe; key_len_data = 3'(ldata);
      #1;
      acc = v && (!m_v || ordy);
      chk("in_ready_rot", ir_rot, !m_v || ordy);
      chk("in_ready_sta", ir_sta, !m_v || ordy);
      cp = ms ? 0 : m_ptr;
      cr = ms ? 0 : m_rot;
      m_ptr = cp; m_rot = cr;
      if (acc) begin
         q_rot.push_back(dir ? er : ref_char(d, m_key[cp], cr));
         q_sta.push_back(dir ? es : ref_char(d, m_key[cp], 0));
         if (is_let(d)) begin
            m_ptr = (cp >= m_len - 1) ? 0 : cp + 1;
            m_rot = (cr == 25) ? 0 : cr + 1;
         end
      end
      m_v = acc ? 1'b1 : (ordy ? 1'b0 : m_v);
      if (kwe) m_key[kaddr] = kdata;
      if (lwe) m_len = (ldata == 0) ? 1 : ((ldata > 4) ? 4 : ldata);
   endtask

   task automatic idle(input bit ordy);
      drive(1'b0, 8'h00, ordy, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic send(input bit ordy, input bit ms);
      drive(1'b1, rand_char(), ordy, ms, 1'b0, 0, 0, 1'b0, 0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic send_dir(input string s, input string er, input string es);
      for (int i = 0; i < s.len(); i++)
         drive(1'b1, s[i], 1'b1, i == 0, 1'b0, 0, 0, 1'b0, 0, 1'b1, er[i], es[i]);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      in_valid = 1'b0; msg_start = 1'b0; key_we = 1'b0; key_len_we = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid_rot", ov_rot, 0);
      chk("rst_out_valid_sta", ov_sta, 0);
      chk("rst_out_data", od_rot, 0);
      chk("rst_key_ptr", kp_rot, 0);
      chk("rst_rotor_pos", rp_rot, 0);
      chk("rst_in_ready", ir_rot, 1);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic monitor();
      bit hold_r = 1'b0, hold_s = 1'b0;
      byte unsigned last_r = 8'h00, last_s = 8'h00, e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q_rot.delete(); q_sta.delete();
            hold_r = 1'b0; hold_s = 1'b0;
         end else begin
            if (hold_r) chk("hold_data_rot", od_rot, last_r);
            if (hold_s) chk("hold_data_sta", od_sta, last_s);
            if (ov_rot && out_ready) begin
               if (q_rot.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL spurious_rot: got char %0d expected none", od_rot);
               end else begin
                  e = q_rot.pop_front();
                  chk("data_rot", od_rot, e);
               end
            end
            if (ov_sta && out_ready) begin
               if (q_sta.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL spurious_sta: got char %0d expected none", od_sta);
               end else begin
                  e = q_sta.pop_front();
                  chk("data_sta", od_sta, e);
               end
            end
            hold_r = ov_rot && !out_ready; last_r = od_rot;
            hold_s = ov_sta && !out_ready; last_s = od_sta;
         end
      end
   endtask

   initial begin
      int key0[4];
      key0 = '{2, 1, 0, 3};
      model_reset();
      fork
         monitor();
      join_none
      do_reset();

      for (int i = 0; i < 4; i++)
         drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, i, key0[i], 1'b0, 0, 1'b0, 8'h00, 8'h00);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 4, 1'b0, 8'h00, 8'h00);

      send_dir("HELL", "KJWU", "KHSO");
      send_dir("KHSO", "HGPR", "HELL");
      send_dir("KJW", "HEL", "HCH");
      idle(1'b1);
      chk("rotor_after_KJW", rp_rot, 3);
      send_dir("H E", "K J", "K H");
      idle(1'b1);
      chk("key_ptr_after_space", kp_rot, 2);

      // Backpressure: five stalled clocks with input still offered
      for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
      for (int i = 0; i < 6; i++) send(1'b1, 1'b0);
      idle(1'b1);

      // Rotor and pointer wrap over a long message
      send(1'b1, 1'b1);
      for (int i = 0; i < 29; i++) send(1'b1, 1'b0);
      idle(1'b1);

      // Length 0 behaves as 1; oversize length clamps
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 6; i++) send(1'b1, 1'b0);
      idle(1'b1);
      chk("key_ptr_len0", kp_rot, 0);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 7, 1'b0, 8'h00, 8'h00);

      for (int i = 0; i < 400; i++)
         drive($urandom_range(0, 3) != 0, rand_char(), $urandom_range(0, 9) < 7,
               $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 29) == 0, $urandom_range(0, 7), 1'b0, 8'h00, 8'h00);

      // Reset while a character is held at the output
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 8; i++) send(1'b1, 1'b0);
      for (int i = 0; i < 4; i++)
         drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, i, $urandom_range(0, 3), 1'b0, 0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 200; i++)
         drive($urandom_range(0, 3) != 0, rand_char(), $urandom_range(0, 9) < 6,
               $urandom_range(0, 19) == 0, 1'b0, 0, 0,
               $urandom_range(0, 29) == 0, $urandom_range(0, 7), 1'b0, 8'h00, 8'h00);

      for (int i = 0; i < 20 && (q_rot.size() + q_sta.size()) != 0; i++) idle(1'b1);
      chk("queue_drained", q_rot.size() + q_sta.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
